// File: rtl/dmem_mmio.sv
// Data memory for a single-cycle core: word RAM in the low region and a
// block of memory-mapped registers (GPIO plus a compare timer) at the top.
module dmem_mmio #(
  parameter int         GPIO_W    = 8,
  parameter int         PRESCALE  = 1,
  parameter logic [9:0] MMIO_BASE = 10'h3F0
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic [9:0]        address_DMEM,
  input  logic [31:0]       write_data_DMEM,
  input  logic              MemWrite,
  input  logic              MemRead,
  output logic [31:0]       data_DMEM,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              timer_irq
);

  localparam int RAM_WORDS = int'(MMIO_BASE);
  localparam int PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_MAX = PW'(PRESCALE - 1);

  localparam logic [9:0] OFF_GPIO_OUT = 10'd0;
  localparam logic [9:0] OFF_GPIO_IN  = 10'd1;
  localparam logic [9:0] OFF_TCNT     = 10'd2;
  localparam logic [9:0] OFF_TCMP     = 10'd3;
  localparam logic [9:0] OFF_TCTRL    = 10'd4;
  localparam logic [9:0] OFF_TSTAT    = 10'd5;

  logic [31:0]       ram_q [RAM_WORDS];

  logic [GPIO_W-1:0] gpio_out_q, gpio_out_d;
  logic [GPIO_W-1:0] sync1_q, sync2_q;
  logic [31:0]       tcnt_q, tcnt_d;
  logic [31:0]       tcmp_q, tcmp_d;
  logic [2:0]        tctrl_q, tctrl_d;
  logic              match_q, match_d;
  logic              irq_q, irq_d;
  logic [PW-1:0]     presc_q, presc_d;

  logic              is_mmio_s;
  logic [9:0]        off_s;
  logic              we_ram_s, we_gout_s, we_tcnt_s, we_tcmp_s, we_tctrl_s, we_tstat_s;
  logic              tick_s, tmatch_s;
  logic [31:0]       rd_s;

  // Address decode and write strobes; writes to RO/unmapped words go nowhere.
  always_comb begin
    is_mmio_s  = (address_DMEM >= MMIO_BASE);
    off_s      = address_DMEM - MMIO_BASE;
    we_ram_s   = MemWrite && !is_mmio_s;
    we_gout_s  = MemWrite && is_mmio_s && (off_s == OFF_GPIO_OUT);
    we_tcnt_s  = MemWrite && is_mmio_s && (off_s == OFF_TCNT);
    we_tcmp_s  = MemWrite && is_mmio_s && (off_s == OFF_TCMP);
    we_tctrl_s = MemWrite && is_mmio_s && (off_s == OFF_TCTRL);
    we_tstat_s = MemWrite && is_mmio_s && (off_s == OFF_TSTAT);
  end

  // Zero-latency read path; sees pre-write state when read and write coincide.
  always_comb begin
    rd_s = 32'h0;
    if (!MemRead) begin
      rd_s = 32'h0;
    end else if (!is_mmio_s) begin
      rd_s = ram_q[address_DMEM];
    end else begin
      case (off_s)
        OFF_GPIO_OUT: rd_s[GPIO_W-1:0] = gpio_out_q;
        OFF_GPIO_IN:  rd_s[GPIO_W-1:0] = sync2_q;
        OFF_TCNT:     rd_s = tcnt_q;
        OFF_TCMP:     rd_s = tcmp_q;
        OFF_TCTRL:    rd_s[2:0] = tctrl_q;
        OFF_TSTAT:    rd_s[0] = match_q;
        default:      rd_s = 32'h0;
      endcase
    end
  end

  assign data_DMEM = rd_s;
  assign gpio_out  = gpio_out_q;
  assign timer_irq = irq_q;

  // Timer next state: a core write to TCNT overrides the tick, and a new
  // match beats a same-cycle W1C clear of the flag.
  always_comb begin
    tick_s   = tctrl_q[0] && (presc_q == PS_MAX);
    tmatch_s = tick_s && (tcnt_q == tcmp_q);

    if (we_tctrl_s && !write_data_DMEM[0]) begin
      presc_d = '0;
    end else if (!tctrl_q[0]) begin
      presc_d = '0;
    end else if (tick_s) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PW'(1);
    end

    if (we_tcnt_s) begin
      tcnt_d = write_data_DMEM;
    end else if (tmatch_s && tctrl_q[1]) begin
      tcnt_d = 32'h0;
    end else if (tick_s) begin
      tcnt_d = tcnt_q + 32'd1;
    end else begin
      tcnt_d = tcnt_q;
    end

    if (tmatch_s) begin
      match_d = 1'b1;
    end else if (we_tstat_s && write_data_DMEM[0]) begin
      match_d = 1'b0;
    end else begin
      match_d = match_q;
    end

    if (we_tcmp_s) begin
      tcmp_d = write_data_DMEM;
    end else begin
      tcmp_d = tcmp_q;
    end

    if (we_tctrl_s) begin
      tctrl_d = write_data_DMEM[2:0];
    end else begin
      tctrl_d = tctrl_q;
    end

    if (we_gout_s) begin
      gpio_out_d = write_data_DMEM[GPIO_W-1:0];
    end else begin
      gpio_out_d = gpio_out_q;
    end

    irq_d = match_d && tctrl_d[2];
  end

  // MMIO register state; reset clears it while RAM is left untouched.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      gpio_out_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      tcnt_q     <= 32'h0;
      tcmp_q     <= 32'h0;
      tctrl_q    <= 3'b000;
      match_q    <= 1'b0;
      irq_q      <= 1'b0;
      presc_q    <= '0;
    end else begin
      gpio_out_q <= gpio_out_d;
      sync1_q    <= gpio_in;
      sync2_q    <= sync1_q;
      tcnt_q     <= tcnt_d;
      tcmp_q     <= tcmp_d;
      tctrl_q    <= tctrl_d;
      match_q    <= match_d;
      irq_q      <= irq_d;
      presc_q    <= presc_d;
    end
  end

  // RAM array, no reset.
  always_ff @(posedge CLK) begin
    if (we_ram_s) begin
      ram_q[address_DMEM] <= write_data_DMEM;
    end
  end

endmodule
